// File: rtl/mem_line_responder.sv
// Line-granular memory responder: accepts tagged read/write line requests and
// answers each one, in acceptance order, a fixed number of cycles later.
module mem_line_responder #(
  parameter int ADDR_W          = 26,
  parameter int LINE_W          = 128,
  parameter int DEPTH           = 256,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic [1:0]                                 req_id,
  input  logic                                       req_we,
  input  logic [ADDR_W-1:0]                          req_addr,
  input  logic [LINE_W-1:0]                          req_data,
  output logic                                       resp_valid,
  input  logic                                       resp_ready,
  output logic [1:0]                                 resp_id,
  output logic [LINE_W-1:0]                          resp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [LINE_W-1:0] mem [DEPTH];

  logic              pipe_valid_reg [LATENCY];
  logic [1:0]        pipe_id_reg    [LATENCY];
  logic [LINE_W-1:0] pipe_data_reg  [LATENCY];

  logic [1:0]        fifo_id_reg    [MAX_OUTSTANDING];
  logic [LINE_W-1:0] fifo_data_reg  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_cnt_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              pop;
  logic              push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign idx       = req_addr[IDX_W-1:0];
  assign req_ready = (count_reg < CNT_W'(MAX_OUTSTANDING)) && !rst;
  assign accept    = req_valid && req_ready;
  assign push      = pipe_valid_reg[LATENCY-1];
  assign pop       = resp_valid && resp_ready;

  assign resp_valid  = (fifo_cnt_reg != '0);
  assign resp_id     = fifo_id_reg[rd_ptr_reg];
  assign resp_data   = fifo_data_reg[rd_ptr_reg];
  assign outstanding = count_reg;

  // Line array: contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      mem[idx] <= req_data;
    end
  end

  // Stage 0 captures the pre-write array contents on a read.
  always_ff @(posedge clk) begin
    pipe_id_reg[0]   <= req_id;
    pipe_data_reg[0] <= req_we ? req_data : mem[idx];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_id_reg[i]   <= pipe_id_reg[i-1];
      pipe_data_reg[i] <= pipe_data_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= 1'b0;
      end
    end else begin
      pipe_valid_reg[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
    end
  end

  // Response FIFO; storage is cleared so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_id_reg[i]   <= '0;
        fifo_data_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_id_reg[wr_ptr_reg]   <= pipe_id_reg[LATENCY-1];
        fifo_data_reg[wr_ptr_reg] <= pipe_data_reg[LATENCY-1];
        wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The credit limit makes these unreachable in correct operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && fifo_cnt_reg == CNT_W'(MAX_OUTSTANDING)));
      assert (!(pop && !accept && count_reg == '0));
      assert (count_reg <= CNT_W'(MAX_OUTSTANDING));
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed table, corner-case sequences and
// random traffic, all checked against a transaction-level model.
module tb_mem_line_responder;

  localparam int ADDR_W  = 26;
  localparam int LINE_W  = 128;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 4;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam int IDX_W   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_id;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [LINE_W-1:0] resp_data;
  logic [CNT_W-1:0]  outstanding;

  always #5 clk = ~clk;

  mem_line_responder #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH),
    .LATENCY(LATENCY), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .outstanding(outstanding)
  );

  // Model: in-flight requests in acceptance order, each with the cycle at
  // which it becomes visible as a response.
  typedef struct {
    logic [1:0]        id;
    logic [LINE_W-1:0] data;
    int                due;
  } flight_t;

  flight_t           q[$];
  logic [LINE_W-1:0] mem_m [DEPTH];
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  int                accepts_seen = 0;
  int                resps_seen = 0;

  logic              seen_ready;
  logic              seen_valid;
  logic [1:0]        seen_id;
  logic [LINE_W-1:0] seen_data;
  logic [CNT_W-1:0]  seen_out;

  typedef struct {
    logic r, v, we;
    logic [1:0]        id;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    logic              rr;
    logic              e_ready, e_valid;
    int                e_out;
    logic              chk;
    logic [1:0]        e_id;
    logic [LINE_W-1:0] e_data;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r, logic v, logic we, logic [1:0] id,
                              logic [ADDR_W-1:0] a, logic [LINE_W-1:0] d, logic rr,
                              logic er, logic ev, int eo, logic ck,
                              logic [1:0] eid, logic [LINE_W-1:0] ed);
    vec_t t;
    t.r = r; t.v = v; t.we = we; t.id = id; t.a = a; t.d = d; t.rr = rr;
    t.e_ready = er; t.e_valid = ev; t.e_out = eo; t.chk = ck;
    t.e_id = eid; t.e_data = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].due <= cyc);
  endfunction

  function automatic bit m_ready(input logic r);
    return !r && (q.size() < MAX_OUT);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic r, input logic v, input logic we,
                      input logic [1:0] id, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] d, input logic rr);
    bit mv, acc, pop;
    flight_t f;
    @(negedge clk);
    rst = r; req_valid = v; req_we = we; req_id = id;
    req_addr = a; req_data = d; resp_ready = rr;
    #1;
    mv = m_valid();
    check("req_ready", req_ready, m_ready(r));
    check("resp_valid", resp_valid, mv);
    check("outstanding", outstanding, q.size());
    if (mv) begin
      check("resp_id", resp_id, q[0].id);
      check("resp_data", resp_data, q[0].data);
    end
    seen_ready = req_ready; seen_valid = resp_valid; seen_id = resp_id;
    seen_data = resp_data; seen_out = outstanding;
    acc = v && m_ready(r);
    pop = mv && rr && !r;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        resps_seen++;
      end
      if (acc) begin
        f.id = id;
        f.data = we ? d : mem_m[a[IDX_W-1:0]];
        f.due = cyc + LATENCY;
        q.push_back(f);
        if (we) mem_m[a[IDX_W-1:0]] = d;
        accepts_seen++;
      end
    end
  endtask

  // Hold one request until the model says it was taken.
  task automatic offer(input logic we, input logic [1:0] id, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, input logic rr);
    int n0;
    n0 = accepts_seen;
    for (int k = 0; k < 50 && accepts_seen == n0; k++) step(0, 1, we, id, a, d, rr);
    check("offer_timeout", accepts_seen != n0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) step(0, 0, 0, 0, 0, 0, 1);
    check("drain_timeout", q.size() == 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [LINE_W-1:0] a5;
    logic [LINE_W-1:0] d1234;
    int acc_dut;
    int r0;
    bit got;

    a5 = {16{8'hA5}};
    d1234 = 128'h1234;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    //        r v we id a       d      rr  er ev eo ck eid ed
    tbl[0]  = mk(1, 0, 0, 0, 0,      0,     1,  0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 'h10,   a5,    1,  1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 2, 'h10,   0,     1,  1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 2, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 2, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 2, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0,      0,     1,  1, 1, 2, 1, 1, a5);
    tbl[7]  = mk(0, 0, 0, 0, 0,      0,     1,  1, 1, 1, 1, 2, a5);
    tbl[8]  = mk(0, 1, 1, 3, 'h110,  d1234, 1,  1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 'h010,  0,     1,  1, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 2, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 2, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0,      0,     1,  1, 1, 2, 1, 3, d1234);
    tbl[14] = mk(0, 0, 0, 0, 0,      0,     1,  1, 1, 1, 1, 0, d1234);
    tbl[15] = mk(0, 0, 0, 0, 0,      0,     1,  1, 0, 0, 0, 0, 0);

    rst = 1; req_valid = 0; req_we = 0; req_id = 0;
    req_addr = 0; req_data = 0; resp_ready = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].we, tbl[i].id, tbl[i].a, tbl[i].d, tbl[i].rr);
      check($sformatf("tbl%0d_ready", i), seen_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_valid", i), seen_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_out", i), seen_out, tbl[i].e_out);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_id", i), seen_id, tbl[i].e_id);
        check($sformatf("tbl%0d_data", i), seen_data, tbl[i].e_data);
      end
    end

    // Give every line used by later reads a known value.
    for (int i = 0; i < 32; i++) offer(1, 2'(i), ADDR_W'(i), rand_line(), 1);
    drain();

    // Backpressure: only MAX_OUT of six offered reads get in.
    acc_dut = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 2'(i), ADDR_W'(i), 0, 0);
      if (seen_ready) acc_dut++;
    end
    check("bp_accepted", acc_dut, MAX_OUT);
    repeat (6) step(0, 0, 0, 0, 0, 0, 0);
    check("bp_ready_low", seen_ready, 0);
    check("bp_outstanding", seen_out, MAX_OUT);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("bp_ready_back", seen_ready, 1);
    drain();

    // Stall hold: response stays put through two refused cycles.
    offer(0, 1, 5, 0, 0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      got = seen_valid;
    end
    check("stall_timeout", got, 1);
    check("stall_id0", seen_id, 1);
    check("stall_data0", seen_data, mem_m[5]);
    step(0, 0, 0, 0, 0, 0, 0);
    check("stall_id1", seen_id, 1);
    check("stall_data1", seen_data, mem_m[5]);
    step(0, 0, 0, 0, 0, 0, 1);
    check("stall_id2", seen_id, 1);
    check("stall_data2", seen_data, mem_m[5]);
    step(0, 0, 0, 0, 0, 0, 0);
    check("stall_one_pop_valid", seen_valid, 0);
    check("stall_one_pop_out", seen_out, 0);

    // Streaming reads with rotating ids.
    r0 = resps_seen;
    for (int i = 0; i < 32; i++) offer(0, 2'(i), ADDR_W'(i), 0, 1);
    drain();
    check("stream_count", resps_seen - r0, 32);

    // Reset with three writes in flight.
    for (int i = 0; i < 3; i++) offer(1, 2'(i), ADDR_W'(40 + i), rand_line(), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_out", seen_out, 0);
    check("rst_valid", seen_valid, 0);
    r0 = resps_seen;
    repeat (LATENCY + 3) step(0, 0, 0, 0, 0, 0, 1);
    check("rst_no_stale", resps_seen - r0, 0);
    for (int i = 0; i < 3; i++) offer(0, 2'(i), ADDR_W'(40 + i), 0, 1);
    drain();
    check("rst_readback_count", resps_seen - r0, 3);

    // Random traffic over aliased addresses.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), 2'($urandom),
           ADDR_W'(($urandom & 32'hFFFF_FF00) | $urandom_range(0, 31)),
           rand_line(), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
